// File: rtl/bitscan_serializer_pkg.sv
// rtl/bitscan_serializer_pkg.sv - shared types and helpers for the bit-scan serializer
package bitscan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } bitscan_state_e;

    // Index width for a request vector; also sizes the downstream decoder's A input.
    function automatic int idx_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bitscan_serializer_if.sv
// rtl/bitscan_serializer_if.sv - request/index handshake bundle for the bit-scan serializer
interface bitscan_serializer_if #(
    parameter int width = 8
) ();
    localparam int IW = bitscan_pkg::idx_width(width);

    logic             InValid;
    logic             InReady;
    logic [width-1:0] InVec;
    logic             OutValid;
    logic             OutReady;
    logic [IW-1:0]    OutIdx;
    logic             OutLast;
    logic             Busy;

    // Producer of vectors / consumer of indices.
    modport master (
        output InValid, InVec, OutReady,
        input  InReady, OutValid, OutIdx, OutLast, Busy
    );

    // The serializer itself.
    modport slave (
        input  InValid, InVec, OutReady,
        output InReady, OutValid, OutIdx, OutLast, Busy
    );
endinterface

// File: rtl/bitscan_serializer_priority_encode_lsb.sv
// rtl/bitscan_serializer_priority_encode_lsb.sv - lowest-set-bit index with zero and one-hot flags
module priority_encode_lsb #(
    parameter int width = 8
) (
    input  logic [width-1:0]                         vec,
    output logic [bitscan_pkg::idx_width(width)-1:0] idx,
    output logic                                     zero,
    output logic                                     single
);
    localparam int IW = bitscan_pkg::idx_width(width);

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        idx = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign zero   = (vec == '0);
    assign single = !zero && ((vec & (vec - width'(1))) == '0);

endmodule

// File: rtl/bitscan_serializer.sv
// rtl/bitscan_serializer.sv - emits the index of each set bit of an accepted vector, lowest first
module bitscan_serializer
    import bitscan_pkg::*;
#(
    parameter int width = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    bitscan_serializer_if.slave  bus
);
    localparam int IW = idx_width(width);

    bitscan_state_e   state, state_nxt;
    logic [width-1:0] res, res_nxt;
    logic [IW-1:0]    lo_idx;
    logic             res_zero;
    logic             res_single;
    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;

    priority_encode_lsb #(.width(width)) u_penc (
        .vec    (res),
        .idx    (lo_idx),
        .zero   (res_zero),
        .single (res_single)
    );

    // Handshake decode, residual update and next state.
    always_comb begin
        state_nxt = state;
        res_nxt   = res;
        out_valid = (state == SCAN);
        // A new vector may enter while the final index of the current one leaves.
        in_ready  = (state == IDLE) || ((state == SCAN) && res_single && bus.OutReady);
        in_fire   = bus.InValid && in_ready;
        out_fire  = out_valid && bus.OutReady;

        if (out_fire) begin
            res_nxt = res & ~(width'(1) << lo_idx);
            // Never linger in SCAN with nothing left to emit.
            if (res_single || res_zero) begin
                state_nxt = IDLE;
            end
        end

        // An all-zero vector is consumed and dropped without producing a beat.
        if (in_fire) begin
            res_nxt   = bus.InVec;
            state_nxt = (bus.InVec != '0) ? SCAN : IDLE;
        end
    end

    // State and residual registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            res   <= '0;
        end else begin
            state <= state_nxt;
            res   <= res_nxt;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.Busy     = (state == SCAN);
    assign bus.OutIdx   = lo_idx;
    assign bus.OutLast  = res_single;

endmodule

// File: tb/tb_bitscan_serializer.sv
// tb/tb_bitscan_serializer.sv - self-checking bench for bitscan_serializer at widths 8, 5 and 16
module tb_bitscan_serializer;

    logic        CLK;
    logic        RSTn;
    int          checks;
    int          errors;
    int          sel;
    int          cur_w;
    logic        in_valid;
    logic [15:0] in_vec;
    logic        out_ready;

    bitscan_serializer_if #(.width(8))  b8 ();
    bitscan_serializer_if #(.width(5))  b5 ();
    bitscan_serializer_if #(.width(16)) b16 ();

    bitscan_serializer #(.width(8))  u8  (.CLK(CLK), .RSTn(RSTn), .bus(b8.slave));
    bitscan_serializer #(.width(5))  u5  (.CLK(CLK), .RSTn(RSTn), .bus(b5.slave));
    bitscan_serializer #(.width(16)) u16 (.CLK(CLK), .RSTn(RSTn), .bus(b16.slave));

    assign b8.InValid   = (sel == 0) && in_valid;
    assign b8.InVec     = in_vec[7:0];
    assign b8.OutReady  = (sel == 0) && out_ready;
    assign b5.InValid   = (sel == 1) && in_valid;
    assign b5.InVec     = in_vec[4:0];
    assign b5.OutReady  = (sel == 1) && out_ready;
    assign b16.InValid  = (sel == 2) && in_valid;
    assign b16.InVec    = in_vec;
    assign b16.OutReady = (sel == 2) && out_ready;

    logic       mv, mrdy, mlast, mbusy;
    logic [3:0] midx;

    always_comb begin
        mv = 1'b0; mrdy = 1'b0; mlast = 1'b0; mbusy = 1'b0; midx = '0;
        case (sel)
            0: begin mv = b8.OutValid;  mrdy = b8.InReady;  mlast = b8.OutLast;  mbusy = b8.Busy;  midx = {1'b0, b8.OutIdx}; end
            1: begin mv = b5.OutValid;  mrdy = b5.InReady;  mlast = b5.OutLast;  mbusy = b5.Busy;  midx = {1'b0, b5.OutIdx}; end
            default: begin mv = b16.OutValid; mrdy = b16.InReady; mlast = b16.OutLast; mbusy = b16.Busy; midx = b16.OutIdx; end
        endcase
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pending indices of the active vector, and the vectors still owed a decoded burst.
    int          q[$];
    logic [15:0] vq[$];
    logic [15:0] acc;

    always @(posedge CLK or negedge RSTn) begin
        bit rdy;
        if (!RSTn) begin
            q.delete();
            vq.delete();
        end else begin
            rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                for (int i = 0; i < cur_w; i++)
                    if (in_vec[i]) q.push_back(i);
                if (in_vec != 0) vq.push_back(in_vec);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus the decoder OR scoreboard.
    always @(negedge CLK) begin
        if (!RSTn) begin
            acc = '0;
        end else begin
            chk("out_valid", {31'd0, mv}, {31'd0, q.size() != 0});
            chk("busy", {31'd0, mbusy}, {31'd0, q.size() != 0});
            chk("in_ready", {31'd0, mrdy},
                {31'd0, (q.size() == 0) || (q.size() == 1 && out_ready)});
            if (q.size() != 0) begin
                chk("out_idx", {28'd0, midx}, q[0]);
                chk("out_last", {31'd0, mlast}, {31'd0, q.size() == 1});
                if (out_ready) begin
                    acc = acc | (16'd1 << midx);
                    if (q.size() == 1) begin
                        if (vq.size() != 0) begin
                            chk("decode_or", {16'd0, acc}, {16'd0, vq[0]});
                            void'(vq.pop_front());
                        end else begin
                            chk("decode_vq", 32'd0, 32'd1);
                        end
                        acc = '0;
                    end
                end
            end
        end
    end

    task automatic lit(input string name, input bit v, input int idx, input bit last, input bit rdy);
        @(negedge CLK);
        chk({name, "_v"}, {31'd0, mv}, {31'd0, v});
        chk({name, "_busy"}, {31'd0, mbusy}, {31'd0, v});
        chk({name, "_rdy"}, {31'd0, mrdy}, {31'd0, rdy});
        if (v) begin
            chk({name, "_idx"}, {28'd0, midx}, idx);
            chk({name, "_last"}, {31'd0, mlast}, {31'd0, last});
        end
        @(posedge CLK); #1;
    endtask

    task automatic accept(input logic [15:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic rand_run(input int s, input int w, input int n);
        logic [15:0] mask;
        sel   = s;
        cur_w = w;
        mask  = 16'((32'd1 << w) - 1);
        for (int c = 0; c < n; c++) begin
            in_valid  = ($urandom % 2) == 0;
            in_vec    = 16'($urandom) & mask;
            if (($urandom % 8) == 0) in_vec = '0;
            out_ready = ($urandom % 4) != 0;
            @(posedge CLK); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (w + 2) begin @(posedge CLK); #1; end
    endtask

    initial begin
        checks = 0; errors = 0; sel = 0; cur_w = 8;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        RSTn = 1'b0;
        #12;
        chk("rst_valid", {31'd0, b8.OutValid}, 32'd0);
        chk("rst_idx", {29'd0, b8.OutIdx}, 32'd0);
        chk("rst_last", {31'd0, b8.OutLast}, 32'd0);
        chk("rst_busy", {31'd0, b8.Busy}, 32'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        lit("post_rst", 0, 0, 0, 1);

        // Basic scan of 1010_0110.
        accept(16'hA6);
        lit("basic0", 1, 1, 0, 0);
        lit("basic1", 1, 2, 0, 0);
        lit("basic2", 1, 5, 0, 0);
        lit("basic3", 1, 7, 1, 1);
        lit("basic_end", 0, 0, 0, 1);

        // Zero vector is dropped.
        accept(16'h00);
        lit("zero0", 0, 0, 0, 1);
        lit("zero1", 0, 0, 0, 1);

        // Backpressure on 0x06.
        out_ready = 1'b0;
        accept(16'h06);
        lit("bp0", 1, 1, 0, 0);
        lit("bp1", 1, 1, 0, 0);
        lit("bp2", 1, 1, 0, 0);
        out_ready = 1'b1;
        lit("bp3", 1, 1, 0, 0);
        lit("bp4", 1, 2, 1, 1);
        lit("bp_end", 0, 0, 0, 1);

        // Back-to-back: 0x80 offered during the last beat of 0x03.
        accept(16'h03);
        lit("b2b0", 1, 0, 0, 0);
        in_valid = 1'b1;
        in_vec   = 16'h80;
        lit("b2b1", 1, 1, 1, 1);
        in_valid = 1'b0;
        lit("b2b2", 1, 7, 1, 1);
        lit("b2b_end", 0, 0, 0, 1);

        // Reset mid-burst after three beats of 0xFF.
        accept(16'hFF);
        lit("mr0", 1, 0, 0, 0);
        lit("mr1", 1, 1, 0, 0);
        lit("mr2", 1, 2, 0, 0);
        #1;
        RSTn = 1'b0;
        #1;
        chk("mr_valid", {31'd0, b8.OutValid}, 32'd0);
        chk("mr_idx", {29'd0, b8.OutIdx}, 32'd0);
        chk("mr_last", {31'd0, b8.OutLast}, 32'd0);
        chk("mr_busy", {31'd0, b8.Busy}, 32'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        lit("mr_after0", 0, 0, 0, 1);
        lit("mr_after1", 0, 0, 0, 1);

        // Full vector: indices 0..7 in order.
        accept(16'hFF);
        for (int i = 0; i < 8; i++)
            lit("full", 1, i, i == 7, i == 7);
        lit("full_end", 0, 0, 0, 1);

        // Random traffic at width 8, 5 and 16.
        rand_run(0, 8, 200);
        rand_run(1, 5, 300);
        rand_run(2, 16, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitscan_serializer.md
# bitscan_serializer

Streaming bit-scan stage that sits directly upstream of the binary-to-one-hot decoder. It accepts a request bit-vector, then emits the binary index of each set bit, lowest first, one index per handshake. Its `OutIdx` is sized to drive the decoder's `A` input directly. The decoder's one-hot outputs, OR-ed over a whole burst, reproduce the accepted vector.

## Interface
- `width`, default 8: request vector width. Legal range is width ≥ 2. Index width is `$clog2(width)`, identical to the decoder's `A` width.

Ports:
- `CLK` input, 1: clock. All state changes on the rising edge.
- `RSTn` input, 1: asynchronous, active-low reset.
- `InValid` input, 1: `InVec` is valid.
- `InReady` output, 1: block accepts `InVec` this cycle.
- `InVec` input, width: request vector. Bit i set means index i is requested.
- `OutValid` output, 1: `OutIdx` is valid.
- `OutReady` input, 1: consumer takes `OutIdx` this cycle.
- `OutIdx` output, `$clog2(width)`: binary index of the lowest remaining set bit.
- `OutLast` output, 1: current index is the final one of this vector.
- `Busy` output, 1: a vector is being serialized.

## Operation
- Registers:
  - state: IDLE or SCAN.
  - residual vector `Res[width-1:0]`.
- IDLE:
  - `InReady`=1, `OutValid`=0.
  - On `InValid`&`InReady` with `InVec`≠0: `Res`←`InVec`, go to SCAN.
  - On `InValid`&`InReady` with `InVec`=0: vector consumed and dropped. No output; stay in IDLE.
- SCAN:
  - `OutValid`=1, `Busy`=1.
  - `OutIdx` = position of the lowest set bit of `Res`.
  - `OutLast` = `Res` has exactly one bit set.
- Beat transfer (`OutValid`&`OutReady`):
  - Clear bit `OutIdx` in `Res`.
  - If `OutLast`, the vector is done.
- `InReady` = IDLE | (SCAN & `OutLast` & `OutReady`). This gives a combinational path `OutReady`→`InReady`, and it is intentional.
- Simultaneous last beat and new accept:
  - `Res`←`InVec`.
  - Stay in SCAN if `InVec`≠0; go to IDLE if `InVec`=0.
- Stall rules:
  - While `OutValid`=1 and `OutReady`=0, `OutIdx`, `OutLast` and `Res` hold.
  - `OutValid` never drops without a transfer.
- Input rule: the block never consumes `InVec` unless `InReady`=1. No ordering requirement on `InValid` toggling.

## Timing
- Latency: a vector accepted at edge t gives its first `OutValid` in the cycle after edge t.
- Throughput:
  - One index per cycle under `OutReady`=1.
  - A k-bit vector takes k cycles.
  - The next vector follows with zero bubble cycles via the simultaneous-accept path.
- `OutIdx`/`OutLast` are combinational from `Res` (a priority encode, no extra register stage). `OutValid` and `Busy` decode directly from the state register.
- Reset values:
  - state=IDLE, `Res`=0.
  - `OutValid`=0, `OutIdx`=0, `OutLast`=0, `Busy`=0.
  - `InReady`=1 once `RSTn` is high.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronous), the remaining `Res` bits are discarded, and no beat completes.

## Structure
- Package `bitscan_pkg`:
  - state enum typedef `bitscan_state_e` {IDLE, SCAN}.
  - helper function `idx_width(width)` returning `$clog2(width)`, shared with the decoder's instantiation.
- Sub-module `priority_encode_lsb`:
  - Parameter `width`.
  - Input vector; outputs index of the lowest set bit, a `zero` flag, and a `single` (one-bit-set) flag.
  - Used for `OutIdx`/`OutLast`.
- Top: state register, `Res` register, clear-bit logic (`Res & ~(1<<OutIdx)`), handshake logic.

## Test plan
- Basic scan: width=8, `InVec`=8'b1010_0110, `OutReady`=1.
  - Expect `OutIdx`=1,2,5,7 on four consecutive cycles.
  - `OutLast`=1 only with 7; `Busy` low in the following cycle.
- Zero vector: `InVec`=8'h00 accepted.
  - `OutValid` stays 0, `InReady` stays 1, state stays IDLE.
- Backpressure: `InVec`=8'h06, `OutReady`=0 for 3 cycles, then 1.
  - `OutIdx`=1 held stable with `OutValid`=1 for 4 cycles, then 2 with `OutLast`=1.
- Back-to-back: second vector 8'h80 presented during the last beat of 8'h03.
  - Accepted in the same cycle.
  - Next cycle `OutIdx`=7, `OutLast`=1, with no bubble.
- Reset mid-burst: `InVec`=8'hFF, `RSTn` pulled low after the 3rd beat.
  - Outputs immediately at reset values.
  - After release, `InReady`=1 and no stale indices appear.
- Full vector plus decoder scoreboard: `InVec`=8'hFF.
  - Indices 0..7 in order.
  - OR of decoded one-hot outputs equals 8'hFF.
  - Repeat with random vectors for width=5 and width=16.
